// File: rtl/sim_halt_monitor_if.sv
// Observation bus between the riscvpipeline CPU/memory signals and sim_halt_monitor.
// The master drives the CPU-side signals; the monitor (slave) drives the status outputs.
interface sim_halt_monitor_if #(
  parameter int CNT_W = 32
) ();
  logic [31:0]      pc;
  logic [31:0]      instr;
  logic [31:0]      addr;
  logic [31:0]      writedata;
  logic             memwrite;

  logic [1:0]       state;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] store_count;
  logic [31:0]      halt_pc;
  logic [31:0]      exit_code;

  modport master (
    output pc, instr, addr, writedata, memwrite,
    input  state, done, timeout, cycle_count, fetch_count, store_count,
           halt_pc, exit_code
  );

  modport slave (
    input  pc, instr, addr, writedata, memwrite,
    output state, done, timeout, cycle_count, fetch_count, store_count,
           halt_pc, exit_code
  );
endinterface

// File: rtl/sim_halt_monitor.sv
// Observe-only run monitor: counts cycles/fetches/stores, halts on EBREAK after a drain
// window, watchdog timeout. Optional tohost exit via macro SIM_HALT_MONITOR_TOHOST_EN.
module sim_halt_monitor #(
  parameter int          CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 5000,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_0FFC
) (
  input  logic               clk,
  input  logic               reset,
  sim_halt_monitor_if.slave  bus
);

  localparam logic [1:0]  ST_RUN     = 2'b00;
  localparam logic [1:0]  ST_DRAIN   = 2'b01;
  localparam logic [1:0]  ST_DONE    = 2'b10;
  localparam logic [1:0]  ST_TIMEOUT = 2'b11;
  localparam logic [31:0] EBREAK     = 32'h0010_0073;
  localparam int          DW         = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] fetch_q, fetch_d;
  logic [CNT_W-1:0] store_q, store_d;
  logic [31:0]      pc_q;
  logic [31:0]      halt_pc_q, halt_pc_d;
  logic [31:0]      exit_q, exit_d;
  logic             active, watchdog, tohost, count_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != '1)) return v + CNT_W'(1);
    return v;
  endfunction

  always_comb begin
    active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    watchdog = active && (64'(cycle_q) == 64'(MAX_CYCLES));
`ifdef SIM_HALT_MONITOR_TOHOST_EN
    tohost   = active && bus.memwrite && (bus.addr == TOHOST_ADDR);
`else
    tohost   = 1'b0;
`endif
    // The watchdog edge itself is not counted, so cycle_count stops exactly at MAX_CYCLES.
    count_en = active && !watchdog;

    cycle_d   = sat_inc(cycle_q, count_en);
    fetch_d   = sat_inc(fetch_q, count_en && (bus.pc != pc_q));
    store_d   = sat_inc(store_q, count_en && bus.memwrite);
    state_d   = state_q;
    drain_d   = drain_q;
    halt_pc_d = halt_pc_q;
    exit_d    = exit_q;

    if (watchdog) begin
      state_d = ST_TIMEOUT;
    end else if (tohost) begin
      state_d = ST_DONE;
`ifdef SIM_HALT_MONITOR_TOHOST_EN
      exit_d  = bus.writedata;
`endif
    end else if (state_q == ST_RUN) begin
      if (bus.instr == EBREAK) begin
        state_d   = ST_DRAIN;
        halt_pc_d = bus.pc;
        drain_d   = DRAIN_INIT;
      end
    end else if (state_q == ST_DRAIN) begin
      if (drain_q == '0) state_d = ST_DONE;
      else               drain_d = drain_q - DW'(1);
    end
  end

`ifndef SIM_HALT_MONITOR_TOHOST_EN
  logic unused_tohost;
  assign unused_tohost = ^{bus.addr, bus.writedata, TOHOST_ADDR};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      drain_q   <= '0;
      cycle_q   <= '0;
      fetch_q   <= '0;
      store_q   <= '0;
      pc_q      <= '0;
      halt_pc_q <= '0;
      exit_q    <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      cycle_q   <= cycle_d;
      fetch_q   <= fetch_d;
      store_q   <= store_d;
      pc_q      <= bus.pc;
      halt_pc_q <= halt_pc_d;
      exit_q    <= exit_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.done        = state_q[1];
  assign bus.timeout     = (state_q == ST_TIMEOUT);
  assign bus.cycle_count = cycle_q;
  assign bus.fetch_count = fetch_q;
  assign bus.store_count = store_q;
  assign bus.halt_pc     = halt_pc_q;
  assign bus.exit_code   = exit_q;

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Bench for sim_halt_monitor: directed scenarios plus randomized runs checked every cycle
// against a history-based model of the run-end rules.
module tb_sim_halt_monitor;
  localparam int          CNT_W  = 32;
  localparam int          MAXC   = 20;
  localparam int          DRAIN  = 4;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sim_halt_monitor_if #(.CNT_W(CNT_W)) bus ();

  sim_halt_monitor #(
    .CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN), .MAX_CYCLES(MAXC), .TOHOST_ADDR(TOHOST)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // History of inputs seen at each edge since the last reset edge (index 1 = first edge).
  logic [31:0] h_pc[0:63];
  logic [31:0] h_ins[0:63];
  logic [31:0] h_addr[0:63];
  logic [31:0] h_wd[0:63];
  logic        h_mw[0:63];
  int          n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic commit();
    if (!reset) begin
      n = 0;
    end else if (n < 63) begin
      n++;
      h_pc[n] = bus.pc; h_ins[n] = bus.instr; h_addr[n] = bus.addr;
      h_wd[n] = bus.writedata; h_mw[n] = bus.memwrite;
    end
  endtask

  // Work out the run outcome from the whole history: which edge ends it and how.
  task automatic predict(output logic [1:0] st, output logic [31:0] cyc, output logic [31:0] fet,
                         output logic [31:0] sto, output logic [31:0] hpc, output logic [31:0] ex);
    int tE, kE, jT, endE, lastC, m;
    bit isTO, drained;
    tE = MAXC + 1;
    kE = 0; jT = 0;
    ex = 32'h0;
`ifdef SIM_HALT_MONITOR_TOHOST_EN
    for (int i = 1; i <= n; i++) if (jT == 0 && h_mw[i] && h_addr[i] == TOHOST) jT = i;
`endif
    for (int i = 1; i <= n; i++)
      if (kE == 0 && h_ins[i] == EBRK && (jT == 0 || i < jT)) kE = i;
    endE = tE; isTO = 1'b1;
    if (kE != 0 && kE < tE && kE + DRAIN + 1 < endE) begin endE = kE + DRAIN + 1; isTO = 1'b0; end
    if (jT != 0 && jT < tE && jT <= endE) begin
      endE = jT; isTO = 1'b0;
      if (n >= jT) ex = h_wd[jT];
    end
    lastC = isTO ? endE - 1 : endE;
    m = (n < lastC) ? n : lastC;
    cyc = 32'(m); fet = 0; sto = 0;
    for (int i = 1; i <= m; i++) begin
      if (h_pc[i] != ((i == 1) ? 32'h0 : h_pc[i-1])) fet++;
      if (h_mw[i]) sto++;
    end
    drained = (kE != 0) && (kE < endE) && (n >= kE);
    hpc = drained ? h_pc[kE] : 32'h0;
    if (n >= endE)    st = isTO ? 2'b11 : 2'b10;
    else if (drained) st = 2'b01;
    else              st = 2'b00;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [1:0]  st;
      logic [31:0] cyc, fet, sto, hpc, ex;
      predict(st, cyc, fet, sto, hpc, ex);
      chk("state",   32'(bus.state),   32'(st));
      chk("done",    32'(bus.done),    32'(st[1]));
      chk("timeout", 32'(bus.timeout), 32'(st == 2'b11));
      chk("cycle",   bus.cycle_count,  cyc);
      chk("fetch",   bus.fetch_count,  fet);
      chk("store",   bus.store_count,  sto);
      chk("halt_pc", bus.halt_pc,      hpc);
      chk("exit",    bus.exit_code,    ex);
    end
  end

  task automatic step(input logic rn, input logic [31:0] p, input logic [31:0] ins,
                      input logic mw, input logic [31:0] a, input logic [31:0] wd);
    reset = rn; bus.pc = p; bus.instr = ins; bus.memwrite = mw; bus.addr = a; bus.writedata = wd;
    @(posedge clk);
    commit();
    #1;
  endtask

  initial begin
    int          len;
    logic [31:0] p, ins, a;
    logic        mw, rn;

    // Reset held for three edges, then ten running edges.
    repeat (3) step(1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    cmp_en = 1'b1;
    chk("rst_state", 32'(bus.state), 32'h0);
    chk("rst_done",  32'(bus.done), 32'h0);
    chk("rst_cycle", bus.cycle_count, 32'h0);
    chk("rst_fetch", bus.fetch_count, 32'h0);
    chk("rst_store", bus.store_count, 32'h0);
    chk("rst_halt",  bus.halt_pc, 32'h0);
    chk("rst_exit",  bus.exit_code, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i * 4), NOP, 1'b0, 32'h0, 32'h0);
    chk("cyc10",   bus.cycle_count, 32'd10);
    chk("fetch10", bus.fetch_count, 32'd9);

    // EBREAK at pc=8, done five edges later.
    step(1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, NOP, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h8, EBRK, 1'b0, 32'h0, 32'h0);
    chk("drain_state", 32'(bus.state), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(12 + 4 * i), NOP, 1'b0, 32'h0, 32'h0);
    chk("done_early", 32'(bus.done), 32'h0);
    step(1'b1, 32'd28, NOP, 1'b0, 32'h0, 32'h0);
    chk("done_k5",   32'(bus.done), 32'h1);
    chk("done_st",   32'(bus.state), 32'h2);
    chk("halt_pc8",  bus.halt_pc, 32'h8);
    chk("cyc_done",  bus.cycle_count, 32'd8);
    chk("fet_done",  bus.fetch_count, 32'd7);
    repeat (3) step(1'b1, 32'h100, EBRK, 1'b1, 32'h0, 32'h0);
    chk("cyc_frozen", bus.cycle_count, 32'd8);
    chk("sto_frozen", bus.store_count, 32'd0);

    // Stalled pc with three stores, then a store to the tohost address.
    step(1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0C, NOP, 1'b0, 32'h0, 32'h0);
    repeat (3) step(1'b1, 32'h10, NOP, 1'b1, 32'h200, 32'h5);
    chk("stall_fetch", bus.fetch_count, 32'd2);
    chk("stores3",     bus.store_count, 32'd3);
    step(1'b1, 32'h14, NOP, 1'b1, TOHOST, 32'h2A);
    chk("tohost_store", bus.store_count, 32'd4);
`ifdef SIM_HALT_MONITOR_TOHOST_EN
    chk("tohost_state", 32'(bus.state), 32'h2);
    chk("tohost_exit",  bus.exit_code, 32'h2A);
`else
    chk("tohost_state", 32'(bus.state), 32'h0);
    chk("tohost_exit",  bus.exit_code, 32'h0);
`endif

    // Watchdog with no EBREAK.
    step(1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < MAXC; i++) step(1'b1, 32'(4 * i), NOP, 1'b0, 32'h0, 32'h0);
    chk("wd_pre_state", 32'(bus.state), 32'h0);
    step(1'b1, 32'h400, NOP, 1'b0, 32'h0, 32'h0);
    chk("wd_state",   32'(bus.state), 32'h3);
    chk("wd_timeout", 32'(bus.timeout), 32'h1);
    chk("wd_done",    32'(bus.done), 32'h1);
    chk("wd_cycle",   bus.cycle_count, 32'd20);

    // EBREAK arriving on the watchdog edge loses to the watchdog.
    step(1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < MAXC; i++) step(1'b1, 32'(4 * i), NOP, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h50, EBRK, 1'b0, 32'h0, 32'h0);
    chk("wd_ebrk_state", 32'(bus.state), 32'h3);
    chk("wd_ebrk_halt",  bus.halt_pc, 32'h0);

    // Reset while draining.
    step(1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h4, EBRK, 1'b1, 32'h0, 32'h0);
    step(1'b1, 32'h8, NOP, 1'b0, 32'h0, 32'h0);
    chk("rd_drain", 32'(bus.state), 32'h1);
    step(1'b0, 32'hC, NOP, 1'b1, 32'h0, 32'h0);
    chk("rd_state", 32'(bus.state), 32'h0);
    chk("rd_cycle", bus.cycle_count, 32'h0);
    chk("rd_store", bus.store_count, 32'h0);
    chk("rd_halt",  bus.halt_pc, 32'h0);
    step(1'b1, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    chk("rd_cycle1", bus.cycle_count, 32'd1);

    // Randomized runs, checked each cycle by the compare process.
    for (int r = 0; r < 60; r++) begin
      step(1'b0, $urandom, $urandom, 1'($urandom), $urandom, $urandom);
      len = $urandom_range(5, 34);
      p = 32'h0;
      for (int c = 0; c < len; c++) begin
        case ($urandom_range(0, 3))
          0, 1:    p = p + 32'h4;
          2:       p = p;
          default: p = $urandom;
        endcase
        ins = ($urandom_range(0, 14) == 0) ? EBRK : $urandom;
        mw  = ($urandom_range(0, 3) == 0);
        a   = ($urandom_range(0, 7) == 0) ? TOHOST : $urandom;
        rn  = ($urandom_range(0, 49) != 0);
        step(rn, p, ins, mw, a, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
